// File: rtl/lfsr_seq_checker_if.sv
// Port bundle for lfsr_seq_checker: word stream in, lock/error status and counters out.
// in_valid qualifies in_data and clear-free words; there is no backpressure, a word is consumed on every edge with in_valid=1.
interface lfsr_seq_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [15:0]      in_data;
    logic             clear;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;
    logic             state_dbg;

    modport master (
        output in_valid, in_data, clear,
        input  locked, err, err_count, word_count, state_dbg
    );

    modport slave (
        input  in_valid, in_data, clear,
        output locked, err, err_count, word_count, state_dbg
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Checks a 16-bit Fibonacci LFSR word stream: searches for a run of valid successors,
// then free-runs its own predictor and flags/counts every mismatching word.
module lfsr_seq_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              nReset,
    lfsr_seq_checker_if.slave bus
);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        ref_q, ref_d;
    logic               ref_ok_q, ref_ok_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

    logic [15:0]        pred;
    logic [RUN_W-1:0]   run_inc;
    logic [MISS_W-1:0]  miss_inc;

    function automatic logic [15:0] lfsr_next(input logic [15:0] w);
        return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
    endfunction

    assign pred     = lfsr_next(ref_q);
    assign run_inc  = run_q + 1'b1;
    assign miss_inc = miss_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        ref_ok_d   = ref_ok_q;
        run_d      = run_q;
        miss_d     = miss_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;

        if (bus.in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    // All-zero is the LFSR lock-up word and can never seed a run.
                    if (bus.in_data == 16'h0000) begin
                        ref_ok_d = 1'b0;
                        run_d    = '0;
                    end else begin
                        ref_d    = bus.in_data;
                        ref_ok_d = 1'b1;
                        if (ref_ok_q && (bus.in_data == pred)) begin
                            run_d = run_inc;
                            if (run_inc == RUN_W'(LOCK_CNT)) begin
                                state_d = ST_LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Predictor advances regardless of the incoming word.
                    ref_d = pred;
                    if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
                    if (bus.in_data != pred) begin
                        err_d  = 1'b1;
                        miss_d = miss_inc;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        if (miss_inc == MISS_W'(LOSS_CNT)) begin
                            state_d  = ST_SEARCH;
                            run_d    = '0;
                            ref_ok_d = 1'b0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
            endcase
        end

        if (bus.clear) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_SEARCH;
            ref_q      <= '0;
            ref_ok_q   <= 1'b0;
            run_q      <= '0;
            miss_q     <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            ref_ok_q   <= ref_ok_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bus.locked     = (state_q == ST_LOCKED);
    assign bus.err        = err_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.word_count = word_cnt_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: vector table, hand sequences for reset/gaps/saturation,
// and a randomized stream checked against a queue-based behavioural model.
module tb_lfsr_seq_checker;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int MAXC     = 65535;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    lfsr_seq_checker_if #(.CNT_W(16)) bus ();
    lfsr_seq_checker_if #(.CNT_W(3))  bus_s ();

    lfsr_seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)) dut (
        .clk(clk), .nReset(nReset), .bus(bus)
    );
    lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(2), .CNT_W(3)) dut_s (
        .clk(clk), .nReset(nReset), .bus(bus_s)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          v;
        logic [15:0] d;
        bit          c;
        bit          l;
        bit          e;
        int          ec;
        int          wc;
    } vec_t;
    vec_t tbl[18];

    logic [33:0] exp_q[$];

    // behavioural model state
    bit          m_locked;
    bit          m_err;
    int          m_ec, m_wc, m_miss;
    logic [15:0] m_pred;
    logic [15:0] chain[$];

    function automatic logic [15:0] m_next(input logic [15:0] w);
        logic fb;
        fb = ^(w & 16'hB400);
        return {w[14:0], fb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input bit l, input bit e, input int ec, input int wc);
        chk({tag, ".locked"}, 32'(bus.locked), 32'(l));
        chk({tag, ".err"}, 32'(bus.err), 32'(e));
        chk({tag, ".err_count"}, 32'(bus.err_count), 32'(ec));
        chk({tag, ".word_count"}, 32'(bus.word_count), 32'(wc));
    endtask

    task automatic cycle_main(input bit v, input logic [15:0] d, input bit c);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_s(input bit v, input logic [15:0] d, input bit c);
        @(negedge clk);
        bus_s.in_valid = v;
        bus_s.in_data  = d;
        bus_s.clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nReset = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
    endtask

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_ec = 0; m_wc = 0; m_miss = 0; m_pred = '0;
        chain.delete();
    endtask

    // Search = grow a chain of successive LFSR words; lock once it spans LOCK_CNT successors.
    task automatic model_step(input bit v, input logic [15:0] d, input bit c);
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (d == 16'h0) chain.delete();
                else if (chain.size() > 0 && d == m_next(chain[chain.size()-1])) chain.push_back(d);
                else begin
                    chain.delete();
                    chain.push_back(d);
                end
                if (chain.size() == LOCK_CNT + 1) begin
                    m_locked = 1; m_pred = d; m_miss = 0;
                    chain.delete();
                end
            end else begin
                m_pred = m_next(m_pred);
                if (m_wc < MAXC) m_wc++;
                if (d != m_pred) begin
                    m_err = 1;
                    if (m_ec < MAXC) m_ec++;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_locked = 0;
                        chain.delete();
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) begin
            m_ec = 0; m_wc = 0;
        end
    endtask

    initial begin
        logic [15:0] s[18];
        logic [15:0] g, t, src, d, flip;
        logic [33:0] e;
        bit          v, c;
        int          r, burst;

        nReset = 1'b0;
        bus.in_valid = 0;   bus.in_data = '0;   bus.clear = 0;
        bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.clear = 0;

        s[0] = 16'hACE1;
        for (int i = 1; i < 18; i++) s[i] = m_next(s[i-1]);

        // lock, single hit, gap, clear, loss of lock, relock
        tbl[0]  = '{1, s[0],  0, 0, 0, 0, 0};
        tbl[1]  = '{1, s[1],  0, 0, 0, 0, 0};
        tbl[2]  = '{1, s[2],  0, 0, 0, 0, 0};
        tbl[3]  = '{1, s[3],  0, 0, 0, 0, 0};
        tbl[4]  = '{1, s[4],  0, 1, 0, 0, 0};
        tbl[5]  = '{1, s[5],  0, 1, 0, 0, 1};
        tbl[6]  = '{1, s[6] ^ 16'h0001, 0, 1, 1, 1, 2};
        tbl[7]  = '{1, s[7],  0, 1, 0, 1, 3};
        tbl[8]  = '{0, 16'hFFFF, 0, 1, 0, 1, 3};
        tbl[9]  = '{1, s[8],  1, 1, 0, 0, 0};
        tbl[10] = '{1, s[9]  ^ 16'h0001, 0, 1, 1, 1, 1};
        tbl[11] = '{1, s[10] ^ 16'h0001, 0, 1, 1, 2, 2};
        tbl[12] = '{1, s[11] ^ 16'h0001, 0, 0, 1, 3, 3};
        tbl[13] = '{1, s[12], 0, 0, 0, 3, 3};
        tbl[14] = '{1, s[13], 0, 0, 0, 3, 3};
        tbl[15] = '{1, s[14], 0, 0, 0, 3, 3};
        tbl[16] = '{1, s[15], 0, 0, 0, 3, 3};
        tbl[17] = '{1, s[16], 0, 1, 0, 3, 3};

        #1;
        check_main("reset", 0, 0, 0, 0);
        @(negedge clk);
        nReset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cycle_main(tbl[i].v, tbl[i].d, tbl[i].c);
            check_main($sformatf("vec%0d", i), tbl[i].l, tbl[i].e, tbl[i].ec, tbl[i].wc);
        end

        // asynchronous reset while locked, observed before the next edge
        cycle_main(1, s[17], 0);
        check_main("pre_rst", 1, 0, 3, 4);
        @(negedge clk);
        #1 nReset = 1'b0;
        #1;
        check_main("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        nReset = 1'b1;

        // all-zero stream never locks
        for (int i = 0; i < 8; i++) begin
            cycle_main(1, 16'h0000, 0);
            check_main($sformatf("zero%0d", i), 0, 0, 0, 0);
        end

        // valid words separated by gaps still lock after 5 words
        g = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            cycle_main(1, g, 0);
            check_main($sformatf("gapw%0d", i), (i == 4), 0, 0, 0);
            cycle_main(0, 16'h0000, 0);
            check_main($sformatf("gap%0d", i), (i == 4), 0, 0, 0);
            g = m_next(g);
        end
        for (int i = 0; i < 3; i++) begin
            cycle_main(0, ~g, 0);
            check_main($sformatf("frozen%0d", i), 1, 0, 0, 0);
        end
        cycle_main(1, g, 0);
        check_main("after_gap", 1, 0, 0, 1);
        g = m_next(g);
        cycle_main(1, g ^ 16'h8000, 0);
        check_main("after_gap_err", 1, 1, 1, 2);
        cycle_main(0, 16'h0000, 0);
        check_main("err_clears", 1, 0, 1, 2);

        // saturation with CNT_W=3, LOSS_CNT=2
        t = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            cycle_s(1, t, 0);
            t = m_next(t);
        end
        chk("sat.locked", 32'(bus_s.locked), 1);
        for (int i = 0; i < 10; i++) begin
            cycle_s(1, t ^ 16'h0004, 0);
            t = m_next(t);
            chk($sformatf("sat.err%0d", i), 32'(bus_s.err), 1);
            chk($sformatf("sat.cnt%0d", i), 32'(bus_s.err_count), (i + 1 > 7) ? 7 : i + 1);
            cycle_s(1, t, 0);
            t = m_next(t);
            chk($sformatf("sat.ok%0d", i), 32'(bus_s.err), 0);
            chk($sformatf("sat.lk%0d", i), 32'(bus_s.locked), 1);
        end
        chk("sat.err_hold", 32'(bus_s.err_count), 7);
        chk("sat.word_hold", 32'(bus_s.word_count), 7);
        cycle_s(1, t ^ 16'h0004, 1);
        t = m_next(t);
        chk("clr.err", 32'(bus_s.err), 1);
        chk("clr.err_count", 32'(bus_s.err_count), 0);
        chk("clr.word_count", 32'(bus_s.word_count), 0);
        cycle_s(0, 16'h0000, 0);

        // randomized stream against the model
        do_reset();
        model_reset();
        src   = 16'h5A5A;
        burst = 0;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 29) == 0);
            d = 16'($urandom);
            if (v) begin
                src = m_next(src);
                d   = src;
                r   = $urandom_range(0, 99);
                flip = 16'h1 << $urandom_range(0, 15);
                if (burst > 0) begin
                    d = d ^ flip;
                    burst--;
                end else if (r < 6) d = d ^ flip;
                else if (r < 8) d = 16'h0000;
                else if (r < 10) begin
                    src = 16'($urandom_range(1, 65535));
                    d   = src;
                end else if (r < 12) begin
                    burst = $urandom_range(1, 3);
                end
            end
            model_step(v, d, c);
            exp_q.push_back({m_locked, m_err, m_ec[15:0], m_wc[15:0]});
            cycle_main(v, d, c);
            e = exp_q.pop_front();
            check_main($sformatf("rnd%0d", i), e[33], e[32], int'(e[31:16]), int'(e[15:0]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
